// File: rtl/clk_switch_pkg.sv
// Shared types and defaults for the clock-select request controller
// and the switch cell that answers it.
package clk_switch_pkg;

   localparam int SEL_W_DEF     = 2;
   localparam int RESET_SEL_DEF = 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_HI,
      ST_WAIT_LO,
      ST_DONE
   } state_t;

endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchronizer, async active-low reset to 0.
module sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_sync <= '0;
      else        r_sync <= {r_sync[STAGES-2:0], i_d};
   end

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/clk_switch_req_ctrl.sv
// Initiator side of the four-phase clock-select req/ack handshake.
// Accepts one select command at a time and reports done/err.
module clk_switch_req_ctrl
   import clk_switch_pkg::*;
#(
   parameter int SEL_W       = SEL_W_DEF,
   parameter int RESET_SEL   = RESET_SEL_DEF,
   parameter int TIMEOUT_CYC = 64,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [SEL_W-1:0] cmd_sel,
   output logic             sw_req,
   output logic [SEL_W-1:0] sw_sel,
   input  logic             sw_ack,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [SEL_W-1:0] cur_sel
);

   localparam int CNT_W =
      (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [SEL_W-1:0] RST_SEL = SEL_W'(RESET_SEL);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic             r_sw_req;
   logic             w_req_nxt;
   logic [SEL_W-1:0] r_sw_sel;
   logic [SEL_W-1:0] w_sel_nxt;
   logic [SEL_W-1:0] r_cur_sel;
   logic [SEL_W-1:0] w_cur_nxt;
   logic             r_err_flag;
   logic             w_errf_nxt;
   logic             r_live;
   logic             w_ack_s;
   logic             w_accept;
   logic             w_to;
   logic             w_wait;

   sync_bit #(
      .STAGES (SYNC_STAGES)
   ) u_ack_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (sw_ack),
      .o_q   (w_ack_s)
   );

   assign cmd_ready = r_live & (r_state == ST_IDLE);
   assign w_accept  = cmd_valid & cmd_ready;
   assign w_wait    = (r_state == ST_WAIT_HI) | (r_state == ST_WAIT_LO);
   // Fires on the edge that would complete TIMEOUT_CYC cycles in a phase
   assign w_to      = (TIMEOUT_CYC != 0) && (r_cnt == CNT_LAST);

   always_comb begin
      w_state_nxt = r_state;
      w_req_nxt   = r_sw_req;
      w_sel_nxt   = r_sw_sel;
      w_cur_nxt   = r_cur_sel;
      w_errf_nxt  = r_err_flag;
      unique case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (cmd_sel == r_cur_sel) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_sel_nxt   = cmd_sel;
                  w_req_nxt   = 1'b1;
                  w_state_nxt = ST_WAIT_HI;
               end
            end
         end
         ST_WAIT_HI: begin
            if (w_ack_s) begin
               w_req_nxt   = 1'b0;
               w_cur_nxt   = r_sw_sel;
               w_state_nxt = ST_WAIT_LO;
            end else if (w_to) begin
               w_req_nxt   = 1'b0;
               w_errf_nxt  = 1'b1;
               w_state_nxt = ST_WAIT_LO;
            end
         end
         ST_WAIT_LO: begin
            if (!w_ack_s) begin
               w_state_nxt = ST_DONE;
            end else if (w_to) begin
               w_errf_nxt  = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_errf_nxt  = 1'b0;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_sw_req   <= 1'b0;
         r_sw_sel   <= RST_SEL;
         r_cur_sel  <= RST_SEL;
         r_err_flag <= 1'b0;
         r_live     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_sw_req   <= w_req_nxt;
         r_sw_sel   <= w_sel_nxt;
         r_cur_sel  <= w_cur_nxt;
         r_err_flag <= w_errf_nxt;
         r_live     <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_state_nxt != r_state) begin
         r_cnt <= '0;
      end else if (w_wait && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign sw_req  = r_sw_req;
   assign sw_sel  = r_sw_sel;
   assign cur_sel = r_cur_sel;
   assign busy    = (r_state != ST_IDLE);
   assign done    = (r_state == ST_DONE);
   assign err     = done & r_err_flag;

endmodule

// File: tb/tb_clk_switch_req_ctrl.sv
// Directed bench for clk_switch_req_ctrl (TIMEOUT_CYC=8, SYNC_STAGES=2).
module tb_clk_switch_req_ctrl;

   logic       clk;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_sel;
   logic       sw_req;
   logic [1:0] sw_sel;
   logic       sw_ack;
   logic       busy;
   logic       done;
   logic       err;
   logic [1:0] cur_sel;

   int n_chk  = 0;
   int n_pass = 0;

   clk_switch_req_ctrl #(
      .SEL_W       (2),
      .RESET_SEL   (0),
      .TIMEOUT_CYC (8),
      .SYNC_STAGES (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_sel   (cmd_sel),
      .sw_req    (sw_req),
      .sw_sel    (sw_sel),
      .sw_ack    (sw_ack),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .cur_sel   (cur_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_sel   = 2'd0;
      sw_ack    = 1'b0;

      #3;
      check("rst_req",   sw_req,    0);
      check("rst_sel",   sw_sel,    0);
      check("rst_cur",   cur_sel,   0);
      check("rst_busy",  busy,      0);
      check("rst_done",  done,      0);
      check("rst_err",   err,       0);
      check("rst_rdy",   cmd_ready, 0);
      repeat (2) tick();
      check("rst_rdy_hold", cmd_ready, 0);
      rst_n = 1'b1;
      check("rdy_pre_edge", cmd_ready, 0);
      tick();
      check("rdy_first_edge", cmd_ready, 1);

      // same select: done on the cycle after accept, no req
      cmd_valid = 1'b1;
      cmd_sel   = 2'd0;
      tick();
      cmd_valid = 1'b0;
      check("same_done", done,      1);
      check("same_err",  err,       0);
      check("same_req",  sw_req,    0);
      check("same_busy", busy,      1);
      check("same_rdy",  cmd_ready, 0);
      tick();
      check("same_done_clr", done,      0);
      check("same_rdy_back", cmd_ready, 1);

      // normal switch to 1
      cmd_valid = 1'b1;
      cmd_sel   = 2'd1;
      tick();
      cmd_valid = 1'b0;
      check("nrm_req_hi", sw_req,  1);
      check("nrm_sel",    sw_sel,  1);
      check("nrm_cur0",   cur_sel, 0);
      repeat (3) tick();
      sw_ack = 1'b1;
      repeat (2) tick();
      check("nrm_req_wait", sw_req,  1);
      check("nrm_cur_wait", cur_sel, 0);
      tick();
      check("nrm_req_lo", sw_req,  0);
      check("nrm_cur1",   cur_sel, 1);
      repeat (3) tick();
      sw_ack = 1'b0;
      repeat (2) tick();
      check("nrm_no_done", done, 0);
      tick();
      check("nrm_done", done, 1);
      check("nrm_err",  err,  0);
      tick();
      check("nrm_done_clr", done,      0);
      check("nrm_rdy",      cmd_ready, 1);

      // timeout: ack never comes
      cmd_valid = 1'b1;
      cmd_sel   = 2'd2;
      tick();
      cmd_valid = 1'b0;
      repeat (7) tick();
      check("to_req_still", sw_req, 1);
      tick();
      check("to_req_drop", sw_req,  0);
      check("to_cur",      cur_sel, 1);
      check("to_sel",      sw_sel,  2);
      check("to_no_done",  done,    0);
      tick();
      check("to_done", done,    1);
      check("to_err",  err,     1);
      check("to_cur2", cur_sel, 1);
      tick();
      check("to_done_clr", done,      0);
      check("to_err_clr",  err,       0);
      check("to_rdy",      cmd_ready, 1);

      // held cmd_valid during busy
      cmd_valid = 1'b1;
      cmd_sel   = 2'd2;
      tick();
      cmd_sel = 2'd3;
      check("hld_sel2", sw_sel, 2);
      sw_ack = 1'b1;
      repeat (3) tick();
      check("hld_req_lo", sw_req,  0);
      check("hld_cur2",   cur_sel, 2);
      sw_ack = 1'b0;
      repeat (3) tick();
      check("hld_done",     done,   1);
      check("hld_sel_busy", sw_sel, 2);
      tick();
      check("hld_rdy",     cmd_ready, 1);
      check("hld_sel_idl", sw_sel,    2);
      tick();
      cmd_valid = 1'b0;
      check("hld_sel3", sw_sel, 3);
      check("hld_req3", sw_req, 1);
      check("hld_busy", busy,   1);

      // reset while in WAIT_HI
      tick();
      rst_n = 1'b0;
      #1;
      check("mid_req",  sw_req,  0);
      check("mid_sel",  sw_sel,  0);
      check("mid_cur",  cur_sel, 0);
      check("mid_busy", busy,    0);
      repeat (2) tick();
      check("mid_no_done", done, 0);
      rst_n = 1'b1;
      tick();
      check("mid_rdy", cmd_ready, 1);

      // stale ack while idle, then a command
      sw_ack = 1'b1;
      repeat (4) tick();
      check("stl_req",  sw_req,    0);
      check("stl_busy", busy,      0);
      check("stl_done", done,      0);
      check("stl_cur",  cur_sel,   0);
      check("stl_rdy",  cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_sel   = 2'd1;
      tick();
      cmd_valid = 1'b0;
      check("stl_req_hi", sw_req, 1);
      tick();
      check("stl_req_lo", sw_req,  0);
      check("stl_cur1",   cur_sel, 1);
      sw_ack = 1'b0;
      repeat (2) tick();
      check("stl_no_done", done, 0);
      tick();
      check("stl_done2", done, 1);
      check("stl_err",   err,  0);
      tick();
      check("stl_rdy2", cmd_ready, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/clk_switch_req_ctrl.md
Name: clk_switch_req_ctrl

Overview:
Initiator side of the clock-select request/acknowledge handshake used by the clock-switching fabric.
- Accepts a target clock-select command over valid/ready in the clk domain.
- Drives a four-phase req/ack handshake toward the switch, which responds with an asynchronous ack.
- Tracks the currently active select and reports completion or timeout.
- Sits between control logic and the glitch-free switch cell.

Parameters:
SEL_W, 2, width of clock-select code
RESET_SEL, 0, select value driven and recorded after reset
TIMEOUT_CYC, 64, max clk cycles waited per ack phase; 0 disables timeout
SYNC_STAGES, 2, synchronizer depth for sw_ack (minimum 2)

Ports:
clk  input  1  control clock
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command (IDLE only)
cmd_sel  input  SEL_W  requested clock select
sw_req  output  1  four-phase request to switch, registered
sw_sel  output  SEL_W  select code presented to switch, registered
sw_ack  input  1  acknowledge from switch, asynchronous to clk
busy  output  1  handshake in progress
done  output  1  one-cycle pulse: command finished
err  output  1  one-cycle pulse, coincident with done: command timed out
cur_sel  output  SEL_W  select confirmed active by last successful handshake

Behaviour:
- Reset: rst_n, asynchronous, active-low; clock clk. While rst_n low, the following values apply:
  - sw_req=0, sw_sel=RESET_SEL, cur_sel=RESET_SEL.
  - busy=0, done=0, err=0, cmd_ready=0.
  - FSM=IDLE, timeout counter=0, synchronizer flops=0.
- After reset release, cmd_ready=1 from the first clock edge.
- sw_ack passes through a SYNC_STAGES-flop synchronizer (ack_s). A change on sw_ack is visible on ack_s SYNC_STAGES edges later. The FSM uses only ack_s.
- FSM states: IDLE, WAIT_HI, WAIT_LO, DONE.
- IDLE:
  - cmd_ready=1. A command is accepted on an edge with cmd_valid&cmd_ready.
  - If cmd_sel==cur_sel: go to DONE; no sw_req activity.
  - Otherwise: sw_sel<=cmd_sel and sw_req<=1 on the same edge, then go to WAIT_HI. sw_req is high from cycle N+1, where N is the accept edge.
- WAIT_HI:
  - sw_req=1 and sw_sel is held stable.
  - On ack_s=1: sw_req<=0, cur_sel<=sw_sel, go to WAIT_LO.
  - On counter reaching TIMEOUT_CYC: sw_req<=0, set internal err_flag, cur_sel unchanged, go to WAIT_LO.
- WAIT_LO:
  - sw_req=0 and sw_sel is still held.
  - On ack_s=0: go to DONE.
  - On counter reaching TIMEOUT_CYC: set err_flag, go to DONE.
- DONE: done=1 and err=err_flag for exactly one cycle, then clear err_flag and go to IDLE.
- Timeout counter:
  - Cleared on every state change; increments each cycle in WAIT_HI/WAIT_LO; saturates.
  - Width $clog2(TIMEOUT_CYC+1).
  - When TIMEOUT_CYC=0, the counter is never compared and the block waits indefinitely.
- busy=1 in WAIT_HI, WAIT_LO, DONE. cmd_ready = ~busy in IDLE after reset.
- cmd_valid held while busy is ignored; it is accepted on the first IDLE cycle. There is no queueing and at most one command is outstanding.
- Minimum back-to-back spacing is 1 IDLE cycle between done and the next accept.
- Boundary cases:
  - ack_s=1 while in IDLE (stale ack): ignored.
  - A new command while ack_s is still high: the request is raised, and the handshake then completes when ack_s is seen high in WAIT_HI.
- Reset mid-handshake: all state returns to reset values immediately. sw_req drops asynchronously and no done pulse is generated.

Decomposition:
- Shared package clk_switch_pkg holds:
  - the FSM state typedef (IDLE, WAIT_HI, WAIT_LO, DONE);
  - the default SEL_W;
  - the RESET_SEL constant, shared with the switch cell.
- Sub-module sync_bit: parameterised SYNC_STAGES-deep single-bit synchronizer with async active-low reset to 0. It is reused by the switch side for sw_req.

Test Plan:
- Normal switch: reset, cmd_sel=1 accepted at cycle 0. Bench raises sw_ack 3 cycles after sw_req, drops it 3 cycles after sw_req falls. Required: sw_req high at cycle 1, sw_sel=1, cur_sel=1 after ack_s rise, done=1 err=0 once, total latency matches SYNC_STAGES arithmetic.
- Same-select: cur_sel=0, cmd_sel=0 → done pulse on cycle 1, sw_req never toggles, err=0.
- Timeout: TIMEOUT_CYC=8, sw_ack held 0 → sw_req drops after 8 WAIT_HI cycles, done=err=1 one cycle, cur_sel unchanged, cmd_ready returns 1.
- Held cmd_valid: issue cmd_sel=2 then hold cmd_valid with cmd_sel=3 during busy → second command accepted only on the first IDLE cycle after done, sw_sel=3 only afterwards.
- Reset mid-operation: assert rst_n low while in WAIT_HI → sw_req=0 and sw_sel=RESET_SEL without waiting for a clock edge, no done. After release, cmd_ready=1 and a new command completes normally.
- Stale ack: sw_ack held 1 while IDLE, no command → no output change. Then issue cmd_sel=1 → completes after ack_s falls, done=1 err=0.
